// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean level into an odd-length burst of
// LFSR-timed toggles followed by a quiet settle window, for self-test.
module bounce_gen #(
  parameter int          TICK     = 1000,
  parameter int          SETTLE_T = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       x,
  input  logic       en,
  output logic       y,
  output logic       busy,
  output logic [2:0] bcnt
);

  localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW = $clog2(SETTLE_T + 1);
  localparam logic [15:0] LSEED = (SEED == 16'h0) ? 16'h0001 : SEED;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BOUNCE = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  logic [15:0]   r_lfsr;
  logic [1:0]    r_state;
  logic          r_y;
  logic          r_busy;
  logic [2:0]    r_bcnt;
  logic [2:0]    r_rem;
  logic [4:0]    r_gap;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_set;

  logic          w_fb;
  logic          w_tick;
  logic [2:0]    w_rem0;
  logic [4:0]    w_gap;

  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_tick = (r_pre == PW'(TICK - 1));
  assign w_rem0 = {r_lfsr[1:0], 1'b0};
  assign w_gap  = {1'b0, r_lfsr[7:4]} + 5'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr  <= LSEED;
      r_state <= S_IDLE;
      r_y     <= 1'b0;
      r_busy  <= 1'b0;
      r_bcnt  <= 3'd0;
      r_rem   <= 3'd0;
      r_gap   <= 5'd0;
      r_pre   <= '0;
      r_set   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      r_pre  <= w_tick ? '0 : r_pre + PW'(1);
      case (r_state)
        S_IDLE: begin
          if (x != r_y) begin
            if (!en) begin
              r_y <= x;
            end else begin
              r_y    <= ~r_y;
              r_rem  <= w_rem0;
              r_bcnt <= {r_lfsr[1:0], 1'b1};
              r_gap  <= w_gap;
              r_pre  <= '0;
              r_busy <= 1'b1;
              if (w_rem0 != 3'd0) begin
                r_state <= S_BOUNCE;
              end else begin
                r_state <= S_SETTLE;
                r_set   <= SW'(SETTLE_T);
              end
            end
          end
        end
        S_BOUNCE: begin
          // gap==1 on a tick means it reaches zero now
          if (w_tick) begin
            if (r_gap == 5'd1) begin
              r_y   <= ~r_y;
              r_rem <= r_rem - 3'd1;
              r_gap <= w_gap;
              if (r_rem == 3'd1) begin
                r_state <= S_SETTLE;
                r_set   <= SW'(SETTLE_T);
              end
            end else begin
              r_gap <= r_gap - 5'd1;
            end
          end
        end
        S_SETTLE: begin
          if (w_tick) begin
            if (r_set == SW'(1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_set <= r_set - SW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign y    = r_y;
  assign busy = r_busy;
  assign bcnt = r_bcnt;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: stimulus queues expected events, a
// negedge monitor detects pass-through changes and bounce events and checks.
module tb_bounce_gen;

  localparam int K_PASS = 0;
  localparam int K_EVT  = 1;

  typedef struct {
    int kind;
    int yv;
    int bc;
    int cy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       x;
  logic       en;
  logic       y;
  logic       busy;
  logic [2:0] bcnt;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_xc = -1;
  bit   free_mode = 1'b0;

  bounce_gen #(.TICK(4), .SETTLE_T(2), .SEED(16'h0001)) dut (
    .clk(clk), .rstn(rstn), .x(x), .en(en),
    .y(y), .busy(busy), .bcnt(bcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(x) last_xc = cyc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  logic py = 1'b0;
  logic pb = 1'b0;
  bit   act = 1'b0;
  int   tog, last_t, start_c, gap;
  exp_t e;

  always @(negedge clk) begin
    if (!rstn) begin
      act = 1'b0;
    end else if (!pb && busy) begin
      chk("first_toggle", int'(y != py), 1);
      act = 1'b1;
      tog = 1;
      last_t = cyc;
      start_c = cyc;
    end else if (busy && y != py) begin
      gap = cyc - last_t;
      chk("gap_mult4", gap % 4, 0);
      chk("gap_range", int'(gap >= 4 && gap <= 64), 1);
      tog++;
      last_t = cyc;
    end else if (pb && !busy && act) begin
      act = 1'b0;
      chk("settle_len", cyc - last_t, 8);
      chk("toggles_eq_bcnt", tog, int'(bcnt));
      chk("bcnt_odd", int'(bcnt[0] == 1'b1), 1);
      if (last_xc < start_c) chk("y_eq_x", int'(y), int'(x));
      if (!free_mode) begin
        chk("sb_has_entry", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("evt_kind", K_EVT, e.kind);
          chk("evt_final_y", int'(y), e.yv);
          if (e.bc >= 0) chk("evt_bcnt", int'(bcnt), e.bc);
        end
      end
    end else if (!pb && !busy && y != py) begin
      chk("pass_in_free", int'(free_mode), 0);
      if (!free_mode) begin
        chk("sb_has_entry", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("pass_kind", K_PASS, e.kind);
          chk("pass_y", int'(y), e.yv);
          chk("pass_latency", cyc, e.cy);
          if (e.bc >= 0) chk("pass_bcnt", int'(bcnt), e.bc);
        end
      end
    end
    py = y;
    pb = busy;
  end

  task automatic push(input int k, input int yv, input int bc);
    exp_t t;
    t.kind = k;
    t.yv = yv;
    t.bc = bc;
    t.cy = cyc + 1;
    q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (n < budget && quiet < 4) begin
      step();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk("idle_reached", int'(quiet >= 4), 1);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (n < budget && !busy) begin
      step();
      n++;
    end
    chk("busy_reached", int'(busy), 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    x = 1'b0;
    en = 1'b1;
    #12;
    chk("rst_y", int'(y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bcnt", int'(bcnt), 0);

    // b) first event after reset: LFSR=0001 -> bcnt 3, ends y=1
    x = 1'b1;
    push(K_EVT, 1, 3);
    #10 rstn = 1'b1;
    wait_idle(2000);

    // a) pass-through, bcnt must stay 3
    en = 1'b0;
    x = 1'b0;
    push(K_PASS, 0, 3);
    repeat (3) step();
    x = 1'b1;
    push(K_PASS, 1, 3);
    repeat (3) step();
    x = 1'b0;
    push(K_PASS, 0, 3);
    repeat (3) step();

    // c) x reverts during bounce: second event on return to idle
    en = 1'b1;
    x = 1'b1;
    push(K_EVT, 1, -1);
    wait_busy(10);
    repeat (2) step();
    x = 1'b0;
    push(K_EVT, 0, -1);
    wait_idle(2000);

    // d) en dropped mid-event, then pass-through
    x = 1'b1;
    push(K_EVT, 1, -1);
    wait_busy(10);
    step();
    en = 1'b0;
    wait_idle(2000);
    x = 1'b0;
    push(K_PASS, 0, -1);
    repeat (3) step();

    // e) reset mid-event aborts; fresh event replays the seed sequence
    en = 1'b1;
    x = 1'b1;
    wait_busy(10);
    repeat (3) step();
    rstn = 1'b0;
    #1;
    chk("rst_mid_y", int'(y), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_bcnt", int'(bcnt), 0);
    @(negedge clk);
    #2;
    push(K_EVT, 1, 3);
    rstn = 1'b1;
    wait_idle(2000);
    chk("sb_drained_directed", q.size(), 0);

    // f) random x changes with bounce enabled
    free_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(40, 1)) step();
      x = ~x;
    end
    wait_idle(5000);
    chk("final_y_eq_x", int'(y), int'(x));
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
